// File: rtl/binconv_chan.sv
// Binary 3x3 XNOR-popcount convolution over a captured 10x10 frame, one output row per clock.
// The finished 8x8 map is published in a single edge so downstream pooling never sees a partial frame.
module binconv_chan #(
    parameter logic [3:0] THRESH = 4'd5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic img_in   [0:9][0:9],
    input  logic weight   [0:2][0:2],
    output logic conv_out [0:7][0:7],
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic       done_q;
    logic       img_q      [0:9][0:9];
    logic       w_q        [0:2][0:2];
    logic       shadow_q   [0:7][0:7];
    logic       conv_out_q [0:7][0:7];
    logic [3:0] sum        [0:7];
    logic       row_bits   [0:7];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                end
            end
            RUN: begin
                row_d = row_q + 3'd1;
                if (row_q == 3'd7) state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Match count for every window on the current row; row_q+u reaches at most 9.
    always_comb begin
        for (int unsigned j = 0; j < 8; j++) begin
            sum[3'(j)] = '0;
            for (int unsigned u = 0; u < 3; u++) begin
                for (int unsigned v = 0; v < 3; v++) begin
                    if (img_q[4'(row_q) + 4'(u)][4'(j + v)] == w_q[2'(u)][2'(v)])
                        sum[3'(j)] = sum[3'(j)] + 4'd1;
                end
            end
            row_bits[3'(j)] = (sum[3'(j)] >= THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            done_q     <= 1'b0;
            img_q      <= '{default: '0};
            w_q        <= '{default: '0};
            shadow_q   <= '{default: '0};
            conv_out_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            done_q  <= (state_q == COMMIT);
            if (state_q == IDLE && start) begin
                img_q <= img_in;
                w_q   <= weight;
            end
            if (state_q == RUN)    shadow_q[row_q] <= row_bits;
            if (state_q == COMMIT) conv_out_q      <= shadow_q;
        end
    end

    assign conv_out = conv_out_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_binconv_chan.sv
// Scoreboard bench: five instances at different thresholds share one stimulus stream;
// expected frames and their commit edges are queued by the driver and checked by a negedge monitor.
module tb_binconv_chan;

    localparam int NI    = 5;
    localparam int KNONE = 32'h7fff_ffff;

    function automatic int th_of(input int g);
        case (g)
            0:       return 5;
            1:       return 9;
            2:       return 8;
            3:       return 0;
            default: return 12;
        endcase
    endfunction

    typedef struct {
        int               acc;
        int               kill;
        logic [4:0][63:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [99:0]      img_p;
    logic [8:0]       wt_p;
    logic             img_u [0:9][0:9];
    logic             w_u   [0:2][0:2];
    logic [4:0][63:0] co_flat;
    logic [4:0]       busy_v;
    logic [4:0]       done_v;

    int   ecnt     = 0;
    logic rst_last = 1'b0;
    logic fin      = 1'b0;
    int   next_ok  = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        ecnt     <= ecnt + 1;
        rst_last <= rst_n;
    end

    for (genvar r = 0; r < 10; r++) begin : g_ir
        for (genvar c = 0; c < 10; c++) begin : g_ic
            assign img_u[r][c] = img_p[r*10 + c];
        end
    end
    for (genvar u = 0; u < 3; u++) begin : g_wr
        for (genvar v = 0; v < 3; v++) begin : g_wc
            assign w_u[u][v] = wt_p[u*3 + v];
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam logic [3:0] TH_G = 4'(th_of(g));
        logic co [0:7][0:7];
        binconv_chan #(.THRESH(TH_G)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start),
            .img_in(img_u), .weight(w_u),
            .conv_out(co), .busy(busy_v[g]), .done(done_v[g])
        );
        for (genvar r = 0; r < 8; r++) begin : g_fr
            for (genvar c = 0; c < 8; c++) begin : g_fc
                assign co_flat[g][r*8 + c] = co[r][c];
            end
        end
    end

    // Window (r,c) covers pixels (r..r+2, c..c+2); output bit is set when matches >= th.
    function automatic logic [63:0] ref_conv(input logic [99:0] im, input logic [8:0] wv, input int th);
        logic [63:0] res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int m = 0;
                for (int u = 0; u < 3; u++)
                    for (int v = 0; v < 3; v++)
                        if (im[(r+u)*10 + c + v] == wv[u*3 + v]) m++;
                res[r*8 + c] = (m >= th);
            end
        end
        return res;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int kill_ofs);
        exp_t e;
        e.acc  = ecnt + 1;
        e.kill = (kill_ofs < 0) ? KNONE : e.acc + kill_ofs;
        for (int g = 0; g < NI; g++) e.data[g] = ref_conv(img_p, wt_p, th_of(g));
        sbq.push_back(e);
    endtask

    task automatic start_frame(input logic [99:0] im, input logic [8:0] wv, input int kill_ofs);
        while (ecnt + 1 < next_ok) cycle();
        img_p = im;
        wt_p  = wv;
        start = 1'b1;
        push_exp(kill_ofs);
        next_ok = ecnt + 1 + 10;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_ready();
        while (ecnt + 1 < next_ok) cycle();
    endtask

    function automatic logic [99:0] rand_img();
        return {4'($urandom), $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input int g, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s th=%0d cyc=%0d got=%h exp=%h", nm, th_of(g), ecnt, got, exp);
        end
    endtask

    // Monitor: timeline model of pending frames; the front entry alone governs busy/done.
    initial begin : monitor
        logic [4:0][63:0] exp_co;
        logic             ex_done, ex_busy;
        exp_co = '0;
        forever begin
            @(negedge clk);
            if (ecnt != 0) begin
                if (!rst_last) exp_co = '0;
                while (sbq.size() > 0 && sbq[0].kill <= ecnt) void'(sbq.pop_front());
                ex_done = (sbq.size() > 0) && (sbq[0].acc + 9 == ecnt);
                ex_busy = (sbq.size() > 0) && (sbq[0].acc <= ecnt) && (ecnt < sbq[0].acc + 9);
                if (ex_done) begin
                    exp_co = sbq[0].data;
                    void'(sbq.pop_front());
                end
                for (int g = 0; g < NI; g++) begin
                    chk("busy", g, 64'(busy_v[g]), 64'(ex_busy));
                    chk("done", g, 64'(done_v[g]), 64'(ex_done));
                    chk("conv_out", g, co_flat[g], exp_co[g]);
                end
            end
            if (ecnt > 5000) begin
                failures++;
                $display("FAIL timeout cyc=%0d got=running exp=finished", ecnt);
            end
            if (fin || ecnt > 5000) begin
                checks++;
                if (sbq.size() != 0) begin
                    failures++;
                    $display("FAIL leftover_frames got=%0d exp=0", sbq.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin : stim
        logic [99:0] ones;
        ones  = '1;
        rst_n = 1'b0;
        start = 1'b0;
        img_p = rand_img();
        wt_p  = 9'($urandom);

        // Reset with random inputs and a start pulse that must be ignored.
        cycle();
        start = 1'b1;
        img_p = rand_img();
        cycle();
        start = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Uniform frames.
        start_frame(ones, 9'h1ff, -1);
        start_frame(ones, 9'h000, -1);
        start_frame('0, 9'h000, -1);

        // Single-pixel localisation.
        begin
            logic [99:0] one_px;
            one_px = '0;
            one_px[55] = 1'b1;
            start_frame(one_px, 9'h010, -1);
        end

        // Busy protection: start and image change at E3 are ignored.
        start_frame(ones, 9'h1ff, -1);
        cycle();
        cycle();
        start = 1'b1;
        img_p = '0;
        cycle();
        start = 1'b0;

        // Back-to-back with start held high.
        wait_ready();
        img_p = ones;
        wt_p  = 9'h1ff;
        start = 1'b1;
        push_exp(-1);
        cycle();
        repeat (9) cycle();
        img_p = '0;
        push_exp(-1);
        cycle();
        start = 1'b0;
        next_ok = ecnt + 10;

        // Reset mid-frame at E4 discards the frame and clears the committed map.
        start_frame(ones, 9'h1ff, -1);
        start_frame(ones, 9'h1ff, 4);
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        next_ok = 0;
        start_frame(rand_img(), 9'($urandom), -1);

        // Random frames with noise on start/img_in while busy.
        for (int n = 0; n < 25; n++) begin
            wait_ready();
            repeat ($urandom_range(0, 3)) cycle();
            start_frame(rand_img(), 9'($urandom), -1);
            for (int k = 0; k < 8; k++) begin
                start = 1'($urandom);
                img_p = rand_img();
                cycle();
            end
            start = 1'b0;
        end

        wait_ready();
        repeat (12) cycle();
        fin = 1'b1;
        repeat (5) cycle();
    end

endmodule
